// File: rtl/rgb2yuv_pkg.sv
// Shared types and constants for the RGB -> YUV444 converter: beat-type
// codes, the two full-range Q8 coefficient sets, rounding and chroma offset.
package rgb2yuv_pkg;

  // Beat-type codes shared with the rest of the pixel pipeline.
  localparam int DTYPE_WIDTH = 4;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_IDLE        = 4'd0;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'd1;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 4'd2;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 4'd3;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 4'd4;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 4'd5;

  // Added before the >>8 so the floor shift rounds to nearest.
  localparam int ROUND_C    = 128;
  // Added to U and V after the shift to centre chroma at mid-scale.
  localparam int CHROMA_OFS = 128;

  // One output row of the matrix: unsigned 8-bit magnitudes plus a sign
  // flag per term, so every product stays an 8x8 unsigned multiply.
  // Index 0 = R, 1 = G, 2 = B.
  typedef struct packed {
    logic [2:0]      neg;
    logic [2:0][7:0] mag;
  } coef_row_t;

  // BT.601 full range
  localparam coef_row_t BT601_Y = '{neg: 3'b000, mag: {8'd29,  8'd150, 8'd77}};
  localparam coef_row_t BT601_U = '{neg: 3'b011, mag: {8'd128, 8'd85,  8'd43}};
  localparam coef_row_t BT601_V = '{neg: 3'b110, mag: {8'd21,  8'd107, 8'd128}};
  // BT.709 full range
  localparam coef_row_t BT709_Y = '{neg: 3'b000, mag: {8'd19,  8'd183, 8'd54}};
  localparam coef_row_t BT709_U = '{neg: 3'b011, mag: {8'd128, 8'd99,  8'd29}};
  localparam coef_row_t BT709_V = '{neg: 3'b110, mag: {8'd12,  8'd116, 8'd128}};

  // Coefficient row for channel ch (0=Y, 1=U, 2=V) of set sel (0=601, 1=709).
  function automatic coef_row_t coef_lookup(input logic sel, input logic [1:0] ch);
    coef_row_t r;
    case (ch)
      2'd0:    r = sel ? BT709_Y : BT601_Y;
      2'd1:    r = sel ? BT709_U : BT601_U;
      default: r = sel ? BT709_V : BT601_V;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rgb2yuv_dot.sv
// Registered 3-term signed dot product for one output channel.
// Cycle 1 registers the three 8x8 products, cycle 2 the rounded signed sum;
// the shift, optional chroma offset and clamp are combinational on the
// sum register so the parent can fold them into its output register.
module rgb2yuv_dot
  import rgb2yuv_pkg::*;
#(
  parameter bit OFFSET_EN = 1'b0
) (
  input  logic            clk,
  input  logic            resetb,
  input  coef_row_t       coef_i,
  input  logic [2:0][7:0] pix_i,
  output logic [7:0]      res_o
);

  logic [2:0][15:0]   prod_d, prod_q;
  logic [2:0]         neg_q;
  logic signed [17:0] sum_d, sum_q;
  logic signed [9:0]  sh, ofs;

  // Unsigned 8x8 products of pixel and coefficient magnitude.
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < 3; i++)
      prod_d[i] = {8'd0, pix_i[i]} * {8'd0, coef_i.mag[i]};
  end

  // Stage 1: products and the matching sign flags.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      prod_q <= '0;
      neg_q  <= '0;
    end else begin
      prod_q <= prod_d;
      neg_q  <= coef_i.neg;
    end
  end

  // Signed accumulation with the rounding constant folded in; 18 bits
  // covers -32640..65408 with margin.
  always_comb begin
    sum_d = 18'(ROUND_C);
    for (int i = 0; i < 3; i++) begin
      if (neg_q[i]) sum_d = sum_d - $signed({2'b00, prod_q[i]});
      else          sum_d = sum_d + $signed({2'b00, prod_q[i]});
    end
  end

  // Stage 2: rounded sum.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) sum_q <= '0;
    else         sum_q <= sum_d;
  end

  // Floor shift, chroma offset and clamp; post-shift range -128..383 fits 10 bits signed.
  always_comb begin
    sh  = 10'(sum_q >>> 8);
    ofs = sh + (OFFSET_EN ? 10'(CHROMA_OFS) : 10'sd0);
    if (ofs < 10'sd0)        res_o = 8'd0;
    else if (ofs > 10'sd255) res_o = 8'd255;
    else                     res_o = ofs[7:0];
  end

endmodule

// File: rtl/rgb2yuv_stage.sv
// RGB -> full-range YUV444 converter ahead of the overlay blender.
// Every beat takes exactly 3 cycles; enable and coefficient set are
// captured on FRAME_START so a frame never mixes modes. Coefficients are
// resolved at the input from sel_q, so the chosen set travels down the
// pipe as products and sign flags alongside the beat's conv flag.
module rgb2yuv_stage
  import rgb2yuv_pkg::*;
#(
  parameter int DTYPE_W = DTYPE_WIDTH
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               enable,
  input  logic               coeff_sel,
  input  logic               dvi,
  input  logic [DTYPE_W-1:0] dtypei,
  input  logic [7:0]         data0i,
  input  logic [7:0]         data1i,
  input  logic [7:0]         data2i,
  input  logic [15:0]        meta_datai,
  output logic               dvo,
  output logic [DTYPE_W-1:0] dtypeo,
  output logic [7:0]         data0o,
  output logic [7:0]         data1o,
  output logic [7:0]         data2o,
  output logic [15:0]        meta_datao,
  output logic               frame_en
);

  localparam logic [DTYPE_W-1:0] DT_FS  = DTYPE_W'(DTYPE_FRAME_START);
  localparam logic [DTYPE_W-1:0] DT_PIX = DTYPE_W'(DTYPE_PIXEL);

  logic frame_en_q, sel_q;
  logic conv_in;
  logic [2:0][7:0] pix_in;
  logic [2:0][7:0] yuv;
  coef_row_t       coef [3];

  // Two internal delay stages; the third stage is the output register.
  logic [1:0]                    vld_pipe_q;
  logic [1:0]                    conv_pipe_q;
  logic [1:0][DTYPE_W-1:0]       dt_pipe_q;
  logic [1:0][15:0]              meta_pipe_q;
  logic [1:0][2:0][7:0]          raw_pipe_q;

  logic               dvo_q;
  logic [DTYPE_W-1:0] dtypeo_q;
  logic [2:0][7:0]    data_q, data_d;
  logic [15:0]        meta_q;

  assign pix_in  = {data2i, data1i, data0i};
  // The FRAME_START beat itself sees the old frame_en_q, so it is never converted.
  assign conv_in = dvi && (dtypei == DT_PIX) && frame_en_q;

  // Per-frame latch of enable and coefficient set.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      frame_en_q <= 1'b0;
      sel_q      <= 1'b0;
    end else if (dvi && (dtypei == DT_FS)) begin
      frame_en_q <= enable;
      sel_q      <= coeff_sel;
    end
  end

  // Y, U, V dot-product units; only the chroma channels take the +128 offset.
  for (genvar c = 0; c < 3; c++) begin : g_ch
    assign coef[c] = coef_lookup(sel_q, 2'(c));
    rgb2yuv_dot #(.OFFSET_EN(c != 0)) u_dot (
      .clk    (clk),
      .resetb (resetb),
      .coef_i (coef[c]),
      .pix_i  (pix_in),
      .res_o  (yuv[c])
    );
  end

  // Delay line for beat metadata and raw data, matched to the dot units.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      vld_pipe_q  <= '0;
      conv_pipe_q <= '0;
      dt_pipe_q   <= '0;
      meta_pipe_q <= '0;
      raw_pipe_q  <= '0;
    end else begin
      vld_pipe_q  <= {vld_pipe_q[0],  dvi};
      conv_pipe_q <= {conv_pipe_q[0], conv_in};
      dt_pipe_q   <= {dt_pipe_q[0],   dtypei};
      meta_pipe_q <= {meta_pipe_q[0], meta_datai};
      raw_pipe_q  <= {raw_pipe_q[0],  pix_in};
    end
  end

  // Converted pixels take the dot results; everything else passes raw.
  always_comb begin
    data_d = conv_pipe_q[1] ? yuv : raw_pipe_q[1];
  end

  // Stage 3: output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      dvo_q    <= 1'b0;
      dtypeo_q <= '0;
      data_q   <= '0;
      meta_q   <= '0;
    end else begin
      dvo_q    <= vld_pipe_q[1];
      dtypeo_q <= dt_pipe_q[1];
      data_q   <= data_d;
      meta_q   <= meta_pipe_q[1];
    end
  end

  assign dvo        = dvo_q;
  assign dtypeo     = dtypeo_q;
  assign data0o     = data_q[0];
  assign data1o     = data_q[1];
  assign data2o     = data_q[2];
  assign meta_datao = meta_q;
  assign frame_en   = frame_en_q;

endmodule

// File: tb/tb_rgb2yuv_stage.sv
// Bench for rgb2yuv_stage: directed vector table, mid-frame reset sequence
// and a random stream against an independent integer reference model.
module tb_rgb2yuv_stage;
  import rgb2yuv_pkg::*;

  localparam int DW = DTYPE_WIDTH;

  typedef struct {
    logic          dv;
    logic [DW-1:0] dt;
    logic [7:0]    d0, d1, d2;
    logic [15:0]   meta;
  } beat_t;

  typedef struct {
    beat_t in;
    logic  en, sel;
    beat_t ex;
    logic  fen;
  } vec_t;

  logic          clk = 1'b0;
  logic          resetb;
  logic          enable, coeff_sel, dvi;
  logic [DW-1:0] dtypei;
  logic [7:0]    data0i, data1i, data2i;
  logic [15:0]   meta_datai;
  logic          dvo;
  logic [DW-1:0] dtypeo;
  logic [7:0]    data0o, data1o, data2o;
  logic [15:0]   meta_datao;
  logic          frame_en;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t exp_q[$];
  vec_t  tbl[$];
  logic  m_fen, m_sel;

  rgb2yuv_stage #(.DTYPE_W(DW)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .coeff_sel(coeff_sel),
    .dvi(dvi), .dtypei(dtypei), .data0i(data0i), .data1i(data1i),
    .data2i(data2i), .meta_datai(meta_datai), .dvo(dvo), .dtypeo(dtypeo),
    .data0o(data0o), .data1o(data1o), .data2o(data2o),
    .meta_datao(meta_datao), .frame_en(frame_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic dv, input logic [DW-1:0] dt,
                               input int d0, input int d1, input int d2, input int meta);
    beat_t b;
    b.dv = dv; b.dt = dt; b.d0 = 8'(d0); b.d1 = 8'(d1); b.d2 = 8'(d2); b.meta = 16'(meta);
    return b;
  endfunction

  // Exact reference arithmetic: round, floor shift, offset, clamp.
  function automatic logic [7:0] chan(input int cr, input int cg, input int cb,
                                      input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b, input bit ofs);
    int s;
    s = cr * int'(r) + cg * int'(g) + cb * int'(b) + 128;
    s = s >>> 8;
    if (ofs) s += 128;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  function automatic beat_t model(input beat_t in);
    beat_t o;
    o = in;
    if (in.dv && in.dt == DTYPE_PIXEL && m_fen) begin
      if (!m_sel) begin
        o.d0 = chan(77, 150, 29, in.d0, in.d1, in.d2, 1'b0);
        o.d1 = chan(-43, -85, 128, in.d0, in.d1, in.d2, 1'b1);
        o.d2 = chan(128, -107, -21, in.d0, in.d1, in.d2, 1'b1);
      end else begin
        o.d0 = chan(54, 183, 19, in.d0, in.d1, in.d2, 1'b0);
        o.d1 = chan(-29, -99, 128, in.d0, in.d1, in.d2, 1'b1);
        o.d2 = chan(128, -116, -12, in.d0, in.d1, in.d2, 1'b1);
      end
    end
    return o;
  endfunction

  // One cycle: drive at negedge, push expectation at the edge, pop and
  // compare the output that is due now (3 cycles after its input).
  task automatic drive(input beat_t in, input logic en, input logic sel, input beat_t ex);
    beat_t e;
    dvi = in.dv; dtypei = in.dt; data0i = in.d0; data1i = in.d1; data2i = in.d2;
    meta_datai = in.meta; enable = en; coeff_sel = sel;
    @(posedge clk);
    exp_q.push_back(ex);
    if (in.dv && in.dt == DTYPE_FRAME_START) begin m_fen = en; m_sel = sel; end
    @(negedge clk);
    e = exp_q.pop_front();
    chk("dvo", int'(dvo), int'(e.dv));
    if (e.dv) begin
      chk("dtypeo", int'(dtypeo), int'(e.dt));
      chk("data0o", int'(data0o), int'(e.d0));
      chk("data1o", int'(data1o), int'(e.d1));
      chk("data2o", int'(data2o), int'(e.d2));
      chk("meta_datao", int'(meta_datao), int'(e.meta));
    end
    chk("frame_en_model", int'(frame_en), int'(m_fen));
  endtask

  task automatic prefill();
    exp_q.delete();
    exp_q.push_back(mk(1'b0, '0, 0, 0, 0, 0));
    exp_q.push_back(mk(1'b0, '0, 0, 0, 0, 0));
  endtask

  task automatic addv(input beat_t in, input logic en, input logic sel,
                      input beat_t ex, input logic fen);
    vec_t v;
    v.in = in; v.en = en; v.sel = sel; v.ex = ex; v.fen = fen;
    tbl.push_back(v);
  endtask

  initial begin
    localparam logic [DW-1:0] FS = DTYPE_FRAME_START;
    localparam logic [DW-1:0] PX = DTYPE_PIXEL;
    localparam logic [DW-1:0] RE = DTYPE_ROW_END;
    beat_t b;
    logic  en, sel;

    // Directed table: {input, enable, coeff_sel, expected output, frame_en after edge}
    addv(mk(1, FS, 0, 0, 0, 1),         1, 0, mk(1, FS, 0, 0, 0, 1),         1);
    addv(mk(1, PX, 255, 255, 255, 2),   1, 0, mk(1, PX, 255, 128, 128, 2),   1);
    addv(mk(1, PX, 255, 0, 0, 3),       1, 0, mk(1, PX, 77, 85, 255, 3),     1);
    addv(mk(1, PX, 0, 0, 255, 4),       1, 0, mk(1, PX, 29, 255, 107, 4),    1);
    addv(mk(1, FS, 9, 9, 9, 5),         1, 1, mk(1, FS, 9, 9, 9, 5),         1);
    addv(mk(1, PX, 255, 0, 0, 6),       1, 1, mk(1, PX, 54, 99, 255, 6),     1);
    addv(mk(1, PX, 0, 0, 0, 7),         1, 1, mk(1, PX, 0, 128, 128, 7),     1);
    addv(mk(1, FS, 4, 5, 6, 8),         0, 0, mk(1, FS, 4, 5, 6, 8),         0);
    addv(mk(1, PX, 10, 20, 30, 9),      1, 0, mk(1, PX, 10, 20, 30, 9),      0);
    addv(mk(1, PX, 10, 20, 30, 10),     1, 1, mk(1, PX, 10, 20, 30, 10),     0);
    addv(mk(1, FS, 7, 7, 7, 11),        1, 0, mk(1, FS, 7, 7, 7, 11),        1);
    addv(mk(1, PX, 10, 20, 30, 12),     0, 1, mk(1, PX, 18, 135, 122, 12),   1);
    addv(mk(1, RE, 1, 2, 3, 'hBEEF),    0, 1, mk(1, RE, 1, 2, 3, 'hBEEF),    1);
    addv(mk(1, PX, 0, 0, 0, 13),        0, 1, mk(1, PX, 0, 128, 128, 13),    1);
    addv(mk(0, PX, 50, 60, 70, 14),     0, 1, mk(0, '0, 0, 0, 0, 0),         1);
    addv(mk(0, PX, 50, 60, 70, 15),     0, 1, mk(0, '0, 0, 0, 0, 0),         1);
    addv(mk(1, RE, 1, 2, 3, 'hBEEF),    0, 1, mk(1, RE, 1, 2, 3, 'hBEEF),    1);
    addv(mk(0, RE, 1, 2, 3, 16),        0, 1, mk(0, '0, 0, 0, 0, 0),         1);
    addv(mk(0, RE, 1, 2, 3, 17),        0, 1, mk(0, '0, 0, 0, 0, 0),         1);
    addv(mk(1, PX, 255, 255, 255, 18),  0, 1, mk(1, PX, 255, 128, 128, 18),  1);
    for (int i = 0; i < 3; i++)
      addv(mk(0, '0, 0, 0, 0, 0),       0, 0, mk(0, '0, 0, 0, 0, 0),         1);

    // Reset state
    resetb = 1'b0; enable = 0; coeff_sel = 0; dvi = 0; dtypei = '0;
    data0i = 0; data1i = 0; data2i = 0; meta_datai = 0;
    m_fen = 0; m_sel = 0;
    repeat (2) @(negedge clk);
    chk("rst_dvo", int'(dvo), 0);
    chk("rst_data0o", int'(data0o), 0);
    chk("rst_meta", int'(meta_datao), 0);
    chk("rst_frame_en", int'(frame_en), 0);
    resetb = 1'b1;
    prefill();

    // Pixel before any FRAME_START is bypassed
    b = mk(1, PX, 200, 100, 50, 'h1234);
    drive(b, 1, 0, b);

    foreach (tbl[i]) begin
      drive(tbl[i].in, tbl[i].en, tbl[i].sel, tbl[i].ex);
      chk($sformatf("tbl%0d_frame_en", i), int'(frame_en), int'(tbl[i].fen));
    end

    // Reset mid-frame with two beats in flight
    drive(mk(1, FS, 0, 0, 0, 1), 1, 0, mk(1, FS, 0, 0, 0, 1));
    drive(mk(1, PX, 255, 0, 0, 2), 1, 0, mk(1, PX, 77, 85, 255, 2));
    drive(mk(1, PX, 0, 0, 255, 3), 1, 0, mk(1, PX, 29, 255, 107, 3));
    #1 resetb = 1'b0;
    #1;
    chk("mrst_dvo", int'(dvo), 0);
    chk("mrst_dtypeo", int'(dtypeo), 0);
    chk("mrst_data1o", int'(data1o), 0);
    chk("mrst_data2o", int'(data2o), 0);
    chk("mrst_meta", int'(meta_datao), 0);
    chk("mrst_frame_en", int'(frame_en), 0);
    m_fen = 0; m_sel = 0;
    @(negedge clk);
    resetb = 1'b1;
    prefill();
    for (int i = 0; i < 4; i++) begin
      b = mk(1, PX, 10, 20, 30, 100 + i);
      drive(b, 1, 1, b);
    end

    // Random stream against the reference model
    en = 0; sel = 0;
    for (int i = 0; i < 10000; i++) begin
      int r;
      logic [DW-1:0] dt;
      r = $urandom_range(0, 99);
      if (r < 3)       dt = FS;
      else if (r < 8)  dt = RE;
      else if (r < 10) dt = DTYPE_FRAME_END;
      else             dt = PX;
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 15) == 0) sel = ~sel;
      b = mk(($urandom_range(0, 9) != 0), dt, $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535));
      drive(b, en, sel, model(b));
    end
    // Drain
    for (int i = 0; i < 3; i++) begin
      b = mk(0, '0, 0, 0, 0, 0);
      drive(b, en, sel, model(b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb2yuv_stage.md
# rgb2yuv_stage

Pixel-stream colour-space converter that sits directly upstream of the overlay stage. It converts RGB pixel beats (8 bits per channel) to full-range YUV444 so that the overlay blender receives Y/U/V in data0/data1/data2. All beats pass through a fixed 3-cycle pipeline. Enable and coefficient selection are latched per frame, so a frame is never split between modes.

## Interface
- DTYPE_W, default `DTYPE_WIDTH: width of the beat-type field.
- clk  in  1  pixel clock.
- resetb  in  1  reset; asynchronous, active-low.
- enable  in  1  convert request; sampled only on a FRAME_START beat.
- coeff_sel  in  1  coefficient set: 0 = BT.601 full range, 1 = BT.709 full range; sampled with enable.
- dvi  in  1  input beat valid.
- dtypei  in  DTYPE_W  input beat type.
- data0i / data1i / data2i  in  8 each  R / G / B on pixel beats; opaque on other beats.
- meta_datai  in  16  sideband data, delayed unchanged.
- dvo  out  1  output beat valid.
- dtypeo  out  DTYPE_W  output beat type.
- data0o / data1o / data2o  out  8 each  Y / U / V on converted pixels; otherwise the delayed input.
- meta_datao  out  16  delayed meta_datai.
- frame_en  out  1  latched per-frame enable (status).

## Operation
- Per-frame latch: when dvi=1 and dtypei=FRAME_START, frame_en <= enable and sel_q <= coeff_sel. Both registers hold their value at all other times.
- Mid-frame changes to enable or coeff_sel have no effect until the next FRAME_START.
- A beat is converted iff dvi=1, dtypei=PIXEL and frame_en=1, evaluated at input. A conv flag and sel_q travel down the pipe with the beat.
- Beats that are not converted (non-pixel beats, or frame_en=0) keep data0..2 unchanged; they are only delayed.
- Coefficients, Q8 (each row sums to 256 for Y and to 0 for U/V):
  - BT.601: Y = 77R+150G+29B; U = -43R-85G+128B; V = 128R-107G-21B.
  - BT.709: Y = 54R+183G+19B; U = -29R-99G+128B; V = 128R-116G-12B.
- Arithmetic per channel:
  - Each product is 8x8 unsigned, giving 16 bits.
  - The signed sum is 18 bits, plus 128 for rounding.
  - Arithmetic shift right by 8 (floor).
  - Add 128 for U and V.
  - Clamp to 0..255.
- Intermediate widths must not overflow: the post-shift range is -128..383, held as 10-bit signed.

## Timing
- Stage 1 registers the 9 products. Stage 2 registers the three rounded sums. Stage 3 applies shift, offset and clamp, and drives the output registers.
- Latency is exactly 3 cycles for every beat, converted or not. dvo, dtypeo and meta_datao are delayed identically to the data.
- No back-pressure. The block accepts a beat every cycle, including back-to-back beats.
- Gaps (dvi=0) propagate as dvo=0 exactly 3 cycles later.
- Reset values: all outputs 0; frame_en = 0; sel_q = 0; all pipeline registers 0, so dvo = 0 for the first 3 cycles after reset release.
- Before the first FRAME_START after reset, frame_en = 0 and the block is in bypass.
- Reset asserted mid-frame discards in-flight beats. The block restarts in bypass until the next FRAME_START.
- FRAME_START at input with enable=1: the FRAME_START beat itself is not converted. The first converted pixel is any PIXEL beat that arrives on a later cycle.

## Structure
- Shared package/defines file: the two Q8 coefficient sets as named constants, the rounding constant 128 and the chroma offset 128. DTYPE_* codes come from the existing dtype definitions.
- One natural sub-module, rgb2yuv_dot: a registered 3-term signed dot product with rounding, shift, optional +128 offset and clamp, exposing 2 cycles of register latency.
  - The top level instantiates three rgb2yuv_dot units (Y, U, V).
  - The top level holds the frame latch and the 3-deep delay line for dv/dtype/meta/raw data/conv flag.
  - The top-level output mux selects converted or raw data using the delayed conv flag.

## Test plan
- BT.601 primaries: FRAME_START with enable=1, coeff_sel=0, then PIXEL (255,255,255), (255,0,0), (0,0,255). Required outputs 3 cycles after each beat: (255,128,128), (77,85,255), (29,255,107). The last two check the V and U clamps.
- BT.709: same frame with coeff_sel=1, PIXEL (255,0,0) -> (54,99,255); PIXEL (0,0,0) -> (0,128,128).
- Bypass/latch: enable=0 at FRAME_START, raised mid-frame. PIXEL (10,20,30) -> (10,20,30) for the rest of the frame. The next FRAME_START converts, and frame_en rises on the cycle after that FRAME_START.
- Framing transparency: a ROW_END beat with data (1,2,3) and meta 0xBEEF, back-to-back with pixels and with 2-cycle gaps. dtypeo, data and meta are unchanged, and the dvo pattern equals the dvi pattern shifted 3 cycles.
- Reset mid-frame: assert resetb low with 2 beats in flight. All outputs are 0 immediately (asynchronously); in-flight beats never appear; frame_en=0. Pixels before the next FRAME_START pass unconverted.
- Random stream: 10k random beats with random enable and coeff_sel toggling. The output is compared against a reference model using the exact floor/clamp arithmetic above.
